// File: rtl/cpu_run_ctrl.sv
// Front-panel run controller: debounced RUN/STEP buttons, HALT/RUN/STEP/FAULT FSM,
// CPU clock enable and status byte for fpga_leds. Define BREAKPOINT_EN for PC breakpoints.

module cpu_run_ctrl_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic zro,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // The level flips on the edge where the counter would reach DB_CYCLES;
    // press fires only when that flip is a 0->1.
    always_ff @(posedge clk) begin
        if (zro) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= ~level;
                cnt   <= '0;
                press <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

module cpu_run_ctrl #(
    parameter int DB_CYCLES = 250000
`ifdef BREAKPOINT_EN
    ,
    parameter int ADDR_W = 8
`endif
) (
    input  logic        clk,
    input  logic        zro,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        cpu_hlt,
    input  logic        cpu_err,
    input  logic [2:0]  cpu_flags,
`ifdef BREAKPOINT_EN
    input  logic        bp_valid,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
`endif
    output logic        cpu_en,
    output logic        run,
    output logic [7:0]  status
);

    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    logic       run_press;
    logic       step_press;
    logic       bp_hit;
    logic [1:0] state;
    logic [1:0] state_next;
    logic       halt_seen;
    logic       halt_seen_next;
    logic [2:0] flags;
    logic [2:0] flags_next;

    cpu_run_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .zro   (zro),
        .btn   (btn_run),
        .press (run_press)
    );

    cpu_run_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk   (clk),
        .zro   (zro),
        .btn   (btn_step),
        .press (step_press)
    );

`ifdef BREAKPOINT_EN
    assign bp_hit = (state == S_RUN) && bp_valid && (pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // A breakpoint hit holds the CPU off for the cycle it would have executed.
    assign cpu_en = !zro && (((state == S_RUN) && !bp_hit) || (state == S_STEP));

    assign flags_next = cpu_en ? cpu_flags : flags;

    always_comb begin
        state_next     = state;
        halt_seen_next = halt_seen;
        case (state)
            S_HALT: begin
                if (run_press) begin
                    state_next     = S_RUN;
                    halt_seen_next = 1'b0;
                end else if (step_press) begin
                    state_next     = S_STEP;
                    halt_seen_next = 1'b0;
                end
            end
            S_RUN: begin
                if (bp_hit) begin
                    state_next     = S_HALT;
                    halt_seen_next = 1'b1;
                end else if (cpu_err) begin
                    state_next = S_FAULT;
                end else if (cpu_hlt) begin
                    state_next     = S_HALT;
                    halt_seen_next = 1'b1;
                end else if (run_press) begin
                    state_next = S_HALT;
                end
            end
            S_STEP: begin
                if (cpu_err) begin
                    state_next = S_FAULT;
                end else begin
                    state_next = S_HALT;
                    if (cpu_hlt) begin
                        halt_seen_next = 1'b1;
                    end
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
        endcase
    end

    // Status is built from next-state values so it lands on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (zro) begin
            state     <= S_HALT;
            halt_seen <= 1'b0;
            flags     <= 3'b000;
            run       <= 1'b0;
            status    <= 8'h00;
        end else begin
            state     <= state_next;
            halt_seen <= halt_seen_next;
            flags     <= flags_next;
            run       <= (state_next == S_RUN);
            status    <= {(state_next == S_RUN), halt_seen_next, (state_next == S_FAULT),
                          flags_next, state_next};
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with DB_CYCLES=4; breakpoint scenario built when BREAKPOINT_EN is defined.

module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       zro = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       cpu_hlt = 1'b0;
    logic       cpu_err = 1'b0;
    logic [2:0] cpu_flags = 3'b000;
    logic       cpu_en;
    logic       run;
    logic [7:0] status;
`ifdef BREAKPOINT_EN
    logic       bp_valid = 1'b0;
    logic [7:0] bp_addr = 8'h00;
    logic [7:0] pc = 8'h00;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        string       tag;
        logic [9:0]  exp;
    } sb_t;

    sb_t sbq[$];

    cpu_run_ctrl #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .zro       (zro),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .cpu_hlt   (cpu_hlt),
        .cpu_err   (cpu_err),
        .cpu_flags (cpu_flags),
`ifdef BREAKPOINT_EN
        .bp_valid  (bp_valid),
        .bp_addr   (bp_addr),
        .pc        (pc),
`endif
        .cpu_en    (cpu_en),
        .run       (run),
        .status    (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Observed word is {cpu_en, run, status}; entries come due on the falling edge.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            checkOutput(sbq[0].tag, {22'd0, cpu_en, run, status}, {22'd0, sbq[0].exp});
            void'(sbq.pop_front());
        end
    end

    function automatic logic [9:0] ev(input logic en, input logic rn, input logic [7:0] st);
        return {en, rn, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectAt(input int n, input string tag, input logic [9:0] exp);
        sb_t e;
        e.due = cyc + n;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    // Clean press: the FSM sees the press pulse on the 7th edge after the raw edge.
    task automatic applyStimulus(input logic pr, input logic ps, input string tag,
                                 input logic [9:0] e_pre, input logic [9:0] e_hit,
                                 input logic [9:0] e_next, input logic [9:0] e_settle);
        expectAt(6, {tag, "_pre"}, e_pre);
        expectAt(7, {tag, "_hit"}, e_hit);
        expectAt(8, {tag, "_next"}, e_next);
        expectAt(17, {tag, "_settle"}, e_settle);
        btn_run  = pr;
        btn_step = ps;
        repeat (10) tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        tick();
        tick();
        expectAt(0, "rst_hold", ev(0, 0, 8'h00));
        zro = 1'b0;
        expectAt(0, "rst_rel", ev(0, 0, 8'h00));
        tick();
        expectAt(0, "rst_idle", ev(0, 0, 8'h00));
        tick();

        applyStimulus(1, 0, "run_on", ev(0, 0, 8'h00), ev(1, 1, 8'h81), ev(1, 1, 8'h81), ev(1, 1, 8'h81));

        btn_run = 1'b1;
        repeat (3) tick();
        btn_run = 1'b0;
        repeat (10) tick();
        expectAt(0, "glitch", ev(1, 1, 8'h81));
        tick();

        cpu_flags = 3'b101;
        tick();
        expectAt(0, "flags_load", ev(1, 1, 8'h95));
        tick();
        cpu_hlt = 1'b1;
        expectAt(0, "hlt_pre", ev(1, 1, 8'h95));
        tick();
        cpu_hlt = 1'b0;
        expectAt(0, "hlt_halt", ev(0, 0, 8'h54));
        tick();
        expectAt(0, "hlt_hold", ev(0, 0, 8'h54));

        cpu_flags = 3'b011;
        applyStimulus(0, 1, "step", ev(0, 0, 8'h54), ev(1, 0, 8'h16), ev(0, 0, 8'h0C), ev(0, 0, 8'h0C));
        applyStimulus(1, 1, "both", ev(0, 0, 8'h0C), ev(1, 1, 8'h8D), ev(1, 1, 8'h8D), ev(1, 1, 8'h8D));
        applyStimulus(0, 1, "step_in_run", ev(1, 1, 8'h8D), ev(1, 1, 8'h8D), ev(1, 1, 8'h8D), ev(1, 1, 8'h8D));
        applyStimulus(1, 0, "run_off", ev(1, 1, 8'h8D), ev(0, 0, 8'h0C), ev(0, 0, 8'h0C), ev(0, 0, 8'h0C));
        applyStimulus(1, 0, "run_again", ev(0, 0, 8'h0C), ev(1, 1, 8'h8D), ev(1, 1, 8'h8D), ev(1, 1, 8'h8D));

        cpu_flags = 3'b000;
        cpu_err = 1'b1;
        cpu_hlt = 1'b1;
        expectAt(0, "err_pre", ev(1, 1, 8'h8D));
        tick();
        cpu_err = 1'b0;
        cpu_hlt = 1'b0;
        cpu_flags = 3'b111;
        expectAt(0, "fault", ev(0, 0, 8'h23));
        tick();
        applyStimulus(1, 0, "fault_run", ev(0, 0, 8'h23), ev(0, 0, 8'h23), ev(0, 0, 8'h23), ev(0, 0, 8'h23));
        applyStimulus(0, 1, "fault_step", ev(0, 0, 8'h23), ev(0, 0, 8'h23), ev(0, 0, 8'h23), ev(0, 0, 8'h23));
        zro = 1'b1;
        tick();
        expectAt(0, "fault_rst", ev(0, 0, 8'h00));
        zro = 1'b0;
        cpu_flags = 3'b000;
        tick();
        expectAt(0, "rst_clear", ev(0, 0, 8'h00));
        tick();

        applyStimulus(1, 0, "run_zro", ev(0, 0, 8'h00), ev(1, 1, 8'h81), ev(1, 1, 8'h81), ev(1, 1, 8'h81));
        zro = 1'b1;
        expectAt(0, "zro_en", ev(0, 1, 8'h81));
        tick();
        zro = 1'b0;
        expectAt(0, "zro_abort", ev(0, 0, 8'h00));
        tick();

`ifdef BREAKPOINT_EN
        applyStimulus(1, 0, "bp_run", ev(0, 0, 8'h00), ev(1, 1, 8'h81), ev(1, 1, 8'h81), ev(1, 1, 8'h81));
        bp_addr  = 8'h10;
        bp_valid = 1'b1;
        pc       = 8'h0E;
        expectAt(0, "bp_0e", ev(1, 1, 8'h81));
        tick();
        pc = 8'h0F;
        expectAt(0, "bp_0f", ev(1, 1, 8'h81));
        tick();
        pc = 8'h10;
        cpu_err = 1'b1;
        expectAt(0, "bp_hit_en", ev(0, 1, 8'h81));
        tick();
        cpu_err = 1'b0;
        expectAt(0, "bp_halt", ev(0, 0, 8'h40));
        tick();
        applyStimulus(0, 1, "bp_step", ev(0, 0, 8'h40), ev(1, 0, 8'h02), ev(0, 0, 8'h00), ev(0, 0, 8'h00));
`endif

        repeat (2) tick();
        checkOutput("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Front-panel run controller sitting directly upstream of fpga_leds.
- Debounces the RUN and STEP buttons and runs the HALT/RUN/STEP/FAULT state machine.
- Gates the CPU clock enable.
- Assembles the 8-bit status byte and run level that fpga_leds displays.
- Shares the board-level zro clear with fpga_leds.

Parameters:
- DB_CYCLES, 250000: consecutive stable cycles before a button level is accepted. Bench uses 4.
- ADDR_W, 8: program-counter width. Used only with BREAKPOINT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- zro  in  1  reset; synchronous, active-high.
- btn_run  in  1  raw RUN/HALT toggle button; asynchronous, bouncy.
- btn_step  in  1  raw single-step button; asynchronous, bouncy.
- cpu_hlt  in  1  CPU executed HLT; valid only while cpu_en=1.
- cpu_err  in  1  CPU illegal opcode/fault; valid only while cpu_en=1.
- cpu_flags  in  3  {N,Z,C} from CPU ALU.
- cpu_en  out  1  CPU clock enable; combinational from state (and breakpoint match).
- run  out  1  registered; 1 iff state==RUN. Drives fpga_leds run.
- status  out  8  registered status byte to fpga_leds.

Behaviour:
Reset:
- zro=1 at a clock edge forces: state=HALT, run=0, status=8'h00, debounce counters=0, debounced levels=0, synchronizers=0.
- zro mid-RUN or mid-STEP aborts the operation; cpu_en drops the same cycle zro is sampled.

Input conditioning (per button):
- 2-flop synchronizer, then debounce.
- Counter, $clog2(DB_CYCLES+1) bits, increments while the synchronized level differs from the debounced level; clears when they match.
- On reaching DB_CYCLES, the debounced level toggles and the counter clears.
- Press event = 1-cycle pulse on a debounced 0->1 transition.
- Latency from a clean raw edge to the press pulse: 2+DB_CYCLES cycles. A glitch shorter than DB_CYCLES produces no event.

State machine (status[1:0] encoding):
- HALT (00): cpu_en=0.
  - run press -> RUN.
  - step press -> STEP.
  - Both presses in the same cycle -> RUN (run wins).
- RUN (01): cpu_en=1.
  - cpu_err -> FAULT.
  - Else cpu_hlt -> HALT and set halt_seen.
  - Else run press -> HALT.
  - Step press ignored.
  - Priority: err > hlt > run press.
- STEP (10): cpu_en=1 for exactly this one cycle; next state HALT unconditionally.
  - cpu_err -> FAULT instead.
  - cpu_hlt sets halt_seen.
- FAULT (11): cpu_en=0; all presses ignored; exit only via zro.

Status byte:
- status = {run_next, halt_seen, fault, flags[2:0], state[1:0]}, all registered, updated every cycle.
- halt_seen (bit 6): sticky; cleared on entry to RUN or STEP.
- fault (bit 5): 1 iff state==FAULT.
- flags (bits 4:2): load cpu_flags on any edge where cpu_en=1; hold otherwise.
- status and run reflect the new state in the same edge that changes state; no extra latency.

Optional Feature:
BREAKPOINT_EN
- Defined: adds ports bp_valid (in, 1) and bp_addr (in, ADDR_W) to match against, plus pc (in, ADDR_W).
  - In RUN, if bp_valid && pc==bp_addr: cpu_en is forced 0 that cycle, next state=HALT, halt_seen set.
  - cpu_err and cpu_hlt are ignored that cycle (the CPU did not execute).
  - STEP never checks the breakpoint, so a step from HALT executes the breakpointed instruction.
- Not defined: these ports and the compare logic are absent; behaviour is exactly as above.

Test Plan:
1. zro=1 for 2 cycles, then 0 -> run=0, cpu_en=0, status=8'h00.
2. DB_CYCLES=4, btn_run held 1 for 10 cycles -> press pulse 6 cycles after the edge; next edge run=1, status=8'h81, cpu_en=1. A 3-cycle btn_run glitch -> no change.
3. In RUN with cpu_flags=3'b101, then cpu_hlt=1 for one cycle -> state HALT, status=8'h54 (halt_seen=1, flags=101, state=00), cpu_en=0 next cycle.
4. In HALT, btn_step press -> cpu_en high exactly 1 cycle, status[1:0]=10 for that one cycle, then HALT. btn_run and btn_step press events in the same cycle -> RUN.
5. In RUN, cpu_err=1 and cpu_hlt=1 in the same cycle -> FAULT, status=8'h23 with flags=000. Further presses leave it unchanged; zro -> 8'h00.
6. (BREAKPOINT_EN) bp_addr=8'h10, bp_valid=1, pc stepping 0E, 0F, 10 in RUN -> cpu_en=0 when pc=8'h10, state HALT, status[6]=1. A subsequent step press executes at pc=8'h10.
